// File: rtl/program_loader.sv
// rtl/program_loader.sv - UART boot loader: length-prefixed big-endian byte stream to instruction-memory writes
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module program_loader #(
  parameter logic [31:0] ADDR_BASE = 32'd0,
  parameter int          DEPTH     = 64
) (
  input  logic        clk_auto,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rxData,
  input  logic        rxValid,
  output logic [31:0] wrAddress,
  output logic [31:0] wrData,
  output logic        wrEnable,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_LAST, S_CHECK, S_DONE, S_ERROR
  } state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] word_q, word_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        we_q, we_d;
  logic [15:0] len_rx;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  assign len_rx = {len_q[15:8], rxData};

  always_ff @(posedge clk_auto) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        // rxValid coinciding with start is deliberately dropped here
        if (start) begin
          state_d = S_LEN_HI;
          idx_d   = '0;
          cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_LEN_HI: begin
        if (rxValid) begin
          len_d[15:8] = rxData;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (rxValid) begin
          len_d[7:0] = rxData;
          if (len_rx == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_DONE;
`endif
          end else if ({1'b0, len_rx} > DEPTH_W) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rxValid) begin
          word_d = {word_q[15:0], rxData};
          cnt_d  = cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rxData;
`endif
          if (cnt_q == 2'd3) begin
            we_d   = 1'b1;
            data_d = {word_q, rxData};
            addr_d = ADDR_BASE + {16'd0, idx_q};
            idx_d  = idx_q + 16'd1;
            if (idx_q == len_q - 16'd1) state_d = S_LAST;
          end
        end
      end
      // One cycle for the final write to be seen before done/check
      S_LAST: begin
`ifdef LOADER_CHECKSUM_EN
        state_d = S_CHECK;
`else
        state_d = S_DONE;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (rxValid) state_d = (rxData == csum_q) ? S_DONE : S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign wrAddress = addr_q;
  assign wrData    = data_q;
  assign wrEnable  = we_q;
  assign busy      = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA) ||
                     (state_q == S_LAST)   || (state_q == S_CHECK);
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - scoreboard bench for program_loader (LOADER_CHECKSUM_EN adds checksum cases)
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset, start, rxValid;
  logic [7:0]  rxData;
  logic [31:0] wrAddress, wrData;
  logic        wrEnable, busy, done, error;

  int total = 0;
  int bad = 0;
  int nwrites = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  program_loader #(.ADDR_BASE(32'd0), .DEPTH(64)) dut (
    .clk_auto(clk), .reset(reset), .start(start), .rxData(rxData), .rxValid(rxValid),
    .wrAddress(wrAddress), .wrData(wrData), .wrEnable(wrEnable),
    .busy(busy), .done(done), .error(error)
  );

  // Monitor: every write strobe is matched against the head of the expected queue
  always @(negedge clk) begin
    if (wrEnable) begin
      nwrites++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: addr=%h data=%h", wrAddress, wrData);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({wrAddress, wrData} !== e) begin
          bad++;
          $display("FAIL write_match: got addr=%h data=%h want addr=%h data=%h",
                   wrAddress, wrData, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rxData  = b;
    rxValid = 1'b1;
    @(negedge clk);
    rxValid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_list(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send(bytes[i]);
  endtask

  initial begin
    int w0;
    reset = 1'b0; start = 1'b0; rxValid = 1'b0; rxData = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_wrAddress", wrAddress, 32'd0);
    chk("rst_wrData", wrData, 32'd0);
    chk("rst_wrEnable", {31'd0, wrEnable}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    reset = 1'b1;
    send_list('{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44});
    chk("idle_no_writes", nwrites, 0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Two-word load, with a stray start while busy
    pulse_start();
    chk("load_busy", {31'd0, busy}, 32'd1);
    exp_q.push_back({32'd0, 32'h68000001});
    exp_q.push_back({32'd1, 32'h70000000});
    send_list('{8'h00, 8'h02, 8'h68, 8'h00});
    pulse_start();
    send_list('{8'h00, 8'h01, 8'h70, 8'h00, 8'h00});
    send(8'h00);
    chk("load_done_lat1", {31'd0, done}, 32'd0);
    chk("load_we_lat1", {31'd0, wrEnable}, 32'd1);
    @(negedge clk);
    chk("load_done", {31'd0, done}, 32'd1);
    chk("load_busy_end", {31'd0, busy}, 32'd0);
    chk("load_error", {31'd0, error}, 32'd0);
    chk("hold_wrData", wrData, 32'h70000000);
    chk("hold_wrAddress", wrAddress, 32'd1);

    // Start with simultaneous byte from DONE: byte is dropped, address restarts at 0
    @(negedge clk);
    start = 1'b1; rxValid = 1'b1; rxData = 8'hFF;
    @(negedge clk);
    start = 1'b0; rxValid = 1'b0;
    chk("restart_done_clr", {31'd0, done}, 32'd0);
    exp_q.push_back({32'd0, 32'hDEADBEEF});
    send_list('{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF});
`ifdef LOADER_CHECKSUM_EN
    send(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
`endif
    @(negedge clk);
    chk("restart_done", {31'd0, done}, 32'd1);

    // Length overflow
    w0 = nwrites;
    pulse_start();
    send_list('{8'h00, 8'h41});
    chk("ovf_error", {31'd0, error}, 32'd1);
    chk("ovf_done", {31'd0, done}, 32'd0);
    chk("ovf_busy", {31'd0, busy}, 32'd0);
    send_list('{8'h01, 8'h02, 8'h03, 8'h04});
    chk("ovf_no_write", nwrites, w0);
    pulse_start();
    chk("ovf_err_clr", {31'd0, error}, 32'd0);

    // Zero length (loader already armed)
    send_list('{8'h00, 8'h00});
`ifdef LOADER_CHECKSUM_EN
    chk("zero_wait_check", {31'd0, busy}, 32'd1);
    send(8'h00);
`endif
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_no_write", nwrites, w0);

    // Exactly-DEPTH length is accepted
    pulse_start();
    send_list('{8'h00, 8'h40});
    chk("depth_busy", {31'd0, busy}, 32'd1);
    chk("depth_error", {31'd0, error}, 32'd0);

    // Reset mid-load after 6 payload bytes of N=3
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    w0 = nwrites;
    pulse_start();
    exp_q.push_back({32'd0, 32'hAABBCCDD});
    send_list('{8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22});
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    send_list('{8'h33, 8'h44, 8'h55, 8'h66});
    chk("midrst_writes", nwrites - w0, 1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_wrAddress", wrAddress, 32'd0);

`ifdef LOADER_CHECKSUM_EN
    pulse_start();
    exp_q.push_back({32'd0, 32'h12345678});
    send_list('{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08});
    chk("csum_pass_done", {31'd0, done}, 32'd1);
    pulse_start();
    exp_q.push_back({32'd0, 32'h12345678});
    send_list('{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'hFF});
    chk("csum_fail_error", {31'd0, error}, 32'd1);
    chk("csum_fail_done", {31'd0, done}, 32'd0);
`endif

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    chk("missing_writes", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
